// File: rtl/spi_dac_if.sv
// SPI link between the Nios-side master and the DAC-model responder.
interface spi_dac_if;
    logic spi_sclk;
    logic spi_ss_n;
    logic spi_mosi;
    logic spi_miso;

    modport master (
        output spi_sclk,
        output spi_ss_n,
        output spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  spi_sclk,
        input  spi_ss_n,
        input  spi_mosi,
        output spi_miso
    );
endinterface

// File: rtl/spi_dac_slave.sv
// DAC-end SPI responder: oversampled frame decode, input/DAC register file,
// LDAC transfer, level clear and register readback on MISO.
module spi_dac_slave #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned FRAME_BITS = 24,
    parameter logic [15:0] CLR_CODE   = 16'h8000
) (
    input  logic                   sys_clk_50m,
    input  logic                   rst_n,
    spi_dac_if.slave               spi,
    input  logic                   ldac_n,
    input  logic                   clr_n,
    output logic [NUM_CH*16-1:0]   dac_code,
    output logic                   frame_valid,
    output logic [3:0]             frame_cmd,
    output logic [3:0]             frame_addr,
    output logic [15:0]            frame_data,
    output logic                   frame_err,
    output logic [7:0]             err_cnt
);

    localparam int unsigned CNT_W    = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

    localparam logic [3:0] CMD_WR_IN   = 4'h1;
    localparam logic [3:0] CMD_WR_BOTH = 4'h2;
    localparam logic [3:0] CMD_RD_SEL  = 4'h9;

    // Synchroniser bit positions and their reset levels (mosi idles low).
    localparam int unsigned S_SCLK = 0;
    localparam int unsigned S_SS   = 1;
    localparam int unsigned S_LDAC = 2;
    localparam int unsigned S_CLR  = 3;
    localparam int unsigned S_MOSI = 4;
    localparam logic [4:0]  SYNC_RST = 5'b01111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    logic [4:0]            sync1_q, sync2_q;
    logic                  sclk_dly_q, ss_dly_q, ldac_dly_q;
    logic                  sclk_rise, sclk_fall, ss_rise, ss_fall, ldac_fall;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] rx_q, rx_d;
    logic [FRAME_BITS-2:0] tx_q, tx_d;
    logic                  miso_q, miso_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic [3:0]            frame_cmd_q, frame_cmd_d;
    logic [3:0]            frame_addr_q, frame_addr_d;
    logic [15:0]           frame_data_q, frame_data_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic [15:0]           in_q [NUM_CH];
    logic [15:0]           in_d [NUM_CH];
    logic [15:0]           dac_q [NUM_CH];
    logic [15:0]           dac_d [NUM_CH];
    logic [3:0]            rd_addr_q, rd_addr_d;

    logic [15:0]           rd_data_c;
    logic [FRAME_BITS-1:0] tx_load_c;

    // Two-stage synchronisers plus one delay stage for edge detection.
    always_ff @(posedge sys_clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= SYNC_RST;
            sync2_q    <= SYNC_RST;
            sclk_dly_q <= 1'b1;
            ss_dly_q   <= 1'b1;
            ldac_dly_q <= 1'b1;
        end else begin
            sync1_q    <= {spi.spi_mosi, clr_n, ldac_n, spi.spi_ss_n, spi.spi_sclk};
            sync2_q    <= sync1_q;
            sclk_dly_q <= sync2_q[S_SCLK];
            ss_dly_q   <= sync2_q[S_SS];
            ldac_dly_q <= sync2_q[S_LDAC];
        end
    end

    assign sclk_rise = sync2_q[S_SCLK] & ~sclk_dly_q;
    assign sclk_fall = ~sync2_q[S_SCLK] & sclk_dly_q;
    assign ss_rise   = sync2_q[S_SS] & ~ss_dly_q;
    assign ss_fall   = ~sync2_q[S_SS] & ss_dly_q;
    assign ldac_fall = ~sync2_q[S_LDAC] & ldac_dly_q;

    // Readback mux: selected input register for the next MISO frame.
    always_comb begin
        rd_data_c = 16'h0000;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_addr_q == 4'(k)) rd_data_c = in_q[k];
        end
    end

    assign tx_load_c = FRAME_BITS'({4'hA, rd_addr_q, rd_data_c});

    // Frame FSM state and shift/report registers.
    always_ff @(posedge sys_clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            rx_q          <= '0;
            tx_q          <= '0;
            miso_q        <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_cmd_q   <= 4'h0;
            frame_addr_q  <= 4'h0;
            frame_data_q  <= 16'h0000;
            err_cnt_q     <= 8'h00;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_q          <= rx_d;
            tx_q          <= tx_d;
            miso_q        <= miso_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            frame_cmd_q   <= frame_cmd_d;
            frame_addr_q  <= frame_addr_d;
            frame_data_q  <= frame_data_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    // Frame FSM next state: shift on sclk edges, judge frame length at the end.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_d          = rx_q;
        tx_d          = tx_q;
        miso_d        = miso_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        frame_cmd_d   = frame_cmd_q;
        frame_addr_d  = frame_addr_q;
        frame_data_d  = frame_data_q;
        err_cnt_d     = err_cnt_q;

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (ss_fall) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                    miso_d    = tx_load_c[FRAME_BITS-1];
                    tx_d      = tx_load_c[FRAME_BITS-2:0];
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d = DONE;
                    miso_d  = 1'b0;
                end else begin
                    if (sclk_rise) begin
                        rx_d = {rx_q[FRAME_BITS-2:0], sync2_q[S_MOSI]};
                        if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                    if (sclk_fall) begin
                        miso_d = tx_q[FRAME_BITS-2];
                        tx_d   = {tx_q[FRAME_BITS-3:0], 1'b0};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                miso_d  = 1'b0;
                if (bit_cnt_q == CNT_FULL) begin
                    frame_valid_d = 1'b1;
                    frame_cmd_d   = rx_q[FRAME_BITS-1 -: 4];
                    frame_addr_d  = rx_q[FRAME_BITS-5 -: 4];
                    frame_data_d  = rx_q[15:0];
                end else begin
                    frame_err_d = 1'b1;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register file: command writes, then LDAC copy, with clear overriding both.
    always_comb begin
        in_d      = in_q;
        dac_d     = dac_q;
        rd_addr_d = rd_addr_q;

        if (frame_valid_q) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (frame_addr_q == 4'(k)) begin
                    if (frame_cmd_q == CMD_WR_IN || frame_cmd_q == CMD_WR_BOTH) in_d[k] = frame_data_q;
                    if (frame_cmd_q == CMD_WR_BOTH) dac_d[k] = frame_data_q;
                end
            end
            if (frame_cmd_q == CMD_RD_SEL && 32'(frame_addr_q) < NUM_CH) rd_addr_d = frame_addr_q;
        end

        if (ldac_fall) dac_d = in_d;

        if (!sync2_q[S_CLR]) begin
            for (int k = 0; k < NUM_CH; k++) begin
                in_d[k]  = CLR_CODE;
                dac_d[k] = CLR_CODE;
            end
        end
    end

    // Register file state.
    always_ff @(posedge sys_clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                in_q[k]  <= CLR_CODE;
                dac_q[k] <= CLR_CODE;
            end
            rd_addr_q <= 4'h0;
        end else begin
            in_q      <= in_d;
            dac_q     <= dac_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_dac
        assign dac_code[16*g +: 16] = dac_q[g];
    end

    assign spi.spi_miso = miso_q;
    assign frame_valid  = frame_valid_q;
    assign frame_err    = frame_err_q;
    assign frame_cmd    = frame_cmd_q;
    assign frame_addr   = frame_addr_q;
    assign frame_data   = frame_data_q;
    assign err_cnt      = err_cnt_q;

endmodule
